// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S transmit sequencer.
//   state_t      : sequencer FSM states (IDLE, RUN, DRAIN)
//   LEFT / RIGHT : channel identifiers used by the slot sequencer
//   LRCLK_LEFT   : LRCLK level that marks a left-channel slot
//   lrclk_level  : maps a channel to its LRCLK level
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  localparam logic LRCLK_LEFT = 1'b0;

  function automatic logic lrclk_level(input logic ch);
    return (ch == LEFT) ? LRCLK_LEFT : ~LRCLK_LEFT;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock generator for the I2S transmit sequencer.
// A divider counts 0..BCLK_DIV-1 while running and is held at 0 otherwise.
// BCLK is low for the first half of the count and high for the second half.
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   run  : divider enable (sequencer not idle)
//   bclk : registered I2S bit clock
//   fe   : combinational strobe, high in the Clk cycle before BCLK falls
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bclk,
  output logic fe
);

  localparam int CW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(BCLK_DIV - 1);
  localparam logic [CW-1:0] DIV_HALF = CW'(BCLK_DIV / 2);

  logic [CW-1:0] div_cnt;
  logic [CW-1:0] div_next;

  assign fe = run && (div_cnt == DIV_LAST);

  always_comb begin
    div_next = fe ? '0 : div_cnt + CW'(1);
  end

  // BCLK is computed from the count it will hold next, so the register and
  // the counter always agree and BCLK falls on the edge that ends the fe cycle.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else begin
      div_cnt <= div_next;
      bclk    <= (div_next >= DIV_HALF);
    end
  end

endmodule

// File: rtl/i2s_tx_sequencer.sv
// I2S (Philips format) transmitter sequencer for one external parallel-load /
// serial-out shift register. Streams a left then a right D_WIDTH-bit slot per
// frame, MSB first, with LRCLK leading the data by one bit.
//   Clk, Reset            : system clock, asynchronous active-high reset
//   Run                   : 1 = stream, 0 = stop after the current frame
//   L_Data, R_Data        : stereo sample pair from the source
//   Sample_Valid/Ready    : pair handshake into a one-deep pair buffer
//   SR_Load/Shift_En/
//   Enable/D/Shift_In     : controls for the external shift register
//   SR_Shift_Out          : serial MSB returned by the shift register
//   BCLK, LRCLK, SDATA    : I2S pins (LRCLK 0 = left)
//   Underrun              : one-Clk pulse when a left slot starts with no pair
module i2s_tx_sequencer
  import i2s_pkg::*;
#(
  parameter int D_WIDTH  = 32,
  parameter int BCLK_DIV = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Run,
  input  logic [D_WIDTH-1:0] L_Data,
  input  logic [D_WIDTH-1:0] R_Data,
  input  logic               Sample_Valid,
  output logic               Sample_Ready,
  output logic               SR_Load,
  output logic               SR_Shift_En,
  output logic               SR_Enable,
  output logic [D_WIDTH-1:0] SR_D,
  output logic               SR_Shift_In,
  input  logic               SR_Shift_Out,
  output logic               BCLK,
  output logic               LRCLK,
  output logic               SDATA,
  output logic               Underrun
);

  localparam int BW = $clog2(D_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(D_WIDTH - 1);
  localparam logic [BW-1:0] PEN_BIT  = BW'(D_WIDTH - 2);

  state_t             state;
  state_t             state_next;
  logic [BW-1:0]      bit_cnt;
  logic               chan;
  logic               fe;
  logic               slot_end;
  logic               stop;
  logic               left_load;
  logic               xfer;
  logic               buf_full;
  logic [D_WIDTH-1:0] buf_l;
  logic [D_WIDTH-1:0] buf_r;
  logic [D_WIDTH-1:0] act_r;

  i2s_bclk_gen #(
    .BCLK_DIV(BCLK_DIV)
  ) u_bclk_gen (
    .clk  (Clk),
    .rst  (Reset),
    .run  (state != IDLE),
    .bclk (BCLK),
    .fe   (fe)
  );

  assign slot_end  = fe && (bit_cnt == LAST_BIT);
  assign left_load = SR_Load && (chan == RIGHT);

  assign Sample_Ready = !buf_full;
  assign xfer         = Sample_Valid && !buf_full;

  assign SR_Enable   = (state != IDLE);
  assign SR_Shift_In = 1'b0;
  assign SDATA       = SR_Shift_Out;

  // A left word goes straight from the pair buffer to the shift register;
  // only the right word has to wait a slot, so only it is held locally.
  assign SR_D = (chan == RIGHT) ? (buf_full ? buf_l : '0) : act_r;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    stop        = 1'b0;
    SR_Load     = 1'b0;
    SR_Shift_En = 1'b0;
    Underrun    = 1'b0;

    unique case (state)
      IDLE:  if (Run) state_next = RUN;
      RUN:   if (!Run) state_next = DRAIN;
      DRAIN: begin
        if (Run) begin
          state_next = RUN;
        end else if (slot_end && (chan == RIGHT)) begin
          // Right slot has fully played out: stop instead of loading left.
          state_next = IDLE;
          stop       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (fe && !stop) begin
      if (bit_cnt == LAST_BIT) SR_Load     = 1'b1;
      else                     SR_Shift_En = 1'b1;
    end

    Underrun = SR_Load && (chan == RIGHT) && !buf_full;
  end

  // Slot sequencing and LRCLK. Idle parks the counters so the first fe after
  // Run loads a LEFT slot; LRCLK switches one bit before the new slot's MSB.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bit_cnt <= LAST_BIT;
      chan    <= RIGHT;
      LRCLK   <= LRCLK_LEFT;
    end else if ((state == IDLE) || stop) begin
      bit_cnt <= LAST_BIT;
      chan    <= RIGHT;
      LRCLK   <= LRCLK_LEFT;
    end else if (fe) begin
      if (SR_Load) begin
        bit_cnt <= '0;
        chan    <= ~chan;
      end else begin
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (bit_cnt == PEN_BIT) LRCLK <= lrclk_level(~chan);
    end
  end

  // Pair buffer and active right word. A transfer coinciding with a left load
  // is only possible with an empty buffer, so the load sends zeros and the
  // later assignment refills the buffer with the new pair.
  // NOTE: the data registers are reset as well, so SR_D never carries stale
  // samples from before a reset into the first slot.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      buf_full <= 1'b0;
      buf_l    <= '0;
      buf_r    <= '0;
      act_r    <= '0;
    end else begin
      if (left_load) begin
        act_r    <= buf_full ? buf_r : '0;
        buf_full <= 1'b0;
      end
      if (xfer) begin
        buf_full <= 1'b1;
        buf_l    <= L_Data;
        buf_r    <= R_Data;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Self-checking bench for i2s_tx_sequencer (D_WIDTH=8, BCLK_DIV=4).
// A behavioural shift register sits on the SR_* pins. A frame-level reference
// model tracks the cycle position inside the stream and the one-deep pair
// buffer, and predicts every output each cycle from plain frame arithmetic.
module tb_i2s_tx_sequencer;

  localparam int DW    = 8;
  localparam int DIV   = 4;
  localparam int SLOT  = DW * DIV;
  localparam int FRAME = 2 * SLOT;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Run;
  logic [DW-1:0] L_Data;
  logic [DW-1:0] R_Data;
  logic          Sample_Valid;
  logic          Sample_Ready;
  logic          SR_Load;
  logic          SR_Shift_En;
  logic          SR_Enable;
  logic [DW-1:0] SR_D;
  logic          SR_Shift_In;
  logic          SR_Shift_Out;
  logic          BCLK;
  logic          LRCLK;
  logic          SDATA;
  logic          Underrun;

  always #5 Clk = ~Clk;

  i2s_tx_sequencer #(
    .D_WIDTH (DW),
    .BCLK_DIV(DIV)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Run         (Run),
    .L_Data      (L_Data),
    .R_Data      (R_Data),
    .Sample_Valid(Sample_Valid),
    .Sample_Ready(Sample_Ready),
    .SR_Load     (SR_Load),
    .SR_Shift_En (SR_Shift_En),
    .SR_Enable   (SR_Enable),
    .SR_D        (SR_D),
    .SR_Shift_In (SR_Shift_In),
    .SR_Shift_Out(SR_Shift_Out),
    .BCLK        (BCLK),
    .LRCLK       (LRCLK),
    .SDATA       (SDATA),
    .Underrun    (Underrun)
  );

  // External shift register: disabled, it streams 0.
  logic [DW-1:0] sr = '0;
  always @(posedge Clk) begin
    if (SR_Enable) begin
      if (SR_Load)          sr <= SR_D;
      else if (SR_Shift_En) sr <= {sr[DW-2:0], SR_Shift_In};
    end
  end
  assign SR_Shift_Out = SR_Enable & sr[DW-1];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state. m_t is the cycle index since the stream started.
  bit            m_active = 1'b0;
  int            m_t      = 0;
  bit            run_prev = 1'b0;
  bit            mb_full  = 1'b0;
  logic [DW-1:0] mb_l     = '0;
  logic [DW-1:0] mb_r     = '0;
  logic [DW-1:0] cur_l    = '0;
  logic [DW-1:0] cur_r    = '0;

  always @(negedge Clk) begin : monitor
    bit            fe;
    bit            slot_edge;
    bit            left_edge;
    bit            stop;
    bit            ld;
    bit            sh;
    bit            und;
    bit            old_full;
    int            u;
    logic [DW-1:0] w;
    logic [DW-1:0] exp_d;

    if (Reset) begin
      check("rst_enable",   32'(SR_Enable),    32'd0);
      check("rst_bclk",     32'(BCLK),         32'd0);
      check("rst_lrclk",    32'(LRCLK),        32'd0);
      check("rst_ready",    32'(Sample_Ready), 32'd1);
      check("rst_load",     32'(SR_Load),      32'd0);
      check("rst_underrun", 32'(Underrun),     32'd0);
      m_active = 1'b0;
      mb_full  = 1'b0;
      run_prev = 1'b0;
    end else begin
      old_full = mb_full;
      check("ready",    32'(Sample_Ready), 32'(!old_full));
      check("shift_in", 32'(SR_Shift_In),  32'd0);

      if (!m_active) begin
        check("idle_load",     32'(SR_Load),     32'd0);
        check("idle_shift",    32'(SR_Shift_En), 32'd0);
        check("idle_underrun", 32'(Underrun),    32'd0);
        check("idle_bclk",     32'(BCLK),        32'd0);
        check("idle_lrclk",    32'(LRCLK),       32'd0);
        check("idle_enable",   32'(SR_Enable),   32'd0);
        check("idle_sdata",    32'(SDATA),       32'd0);
        if (Run) begin
          m_active = 1'b1;
          m_t      = 0;
        end
      end else begin
        fe        = (m_t % DIV) == DIV - 1;
        slot_edge = fe && ((m_t % SLOT) == DIV - 1);
        left_edge = slot_edge && ((m_t % FRAME) == DIV - 1);
        stop      = left_edge && !run_prev && !Run;
        ld        = slot_edge && !stop;
        sh        = fe && !slot_edge;
        und       = left_edge && !stop && !old_full;

        check("load",     32'(SR_Load),     32'(ld));
        check("shift_en", 32'(SR_Shift_En), 32'(sh));
        check("underrun", 32'(Underrun),    32'(und));
        check("enable",   32'(SR_Enable),   32'd1);
        check("bclk",     32'(BCLK),        32'((m_t % DIV) >= DIV / 2));
        check("lrclk",    32'(LRCLK),       32'((m_t % FRAME) >= SLOT));

        if (m_t >= DIV) begin
          u = m_t - DIV;
          w = ((u % FRAME) < SLOT) ? cur_l : cur_r;
          check("sdata", 32'(SDATA), 32'(w[DW-1-(u%SLOT)/DIV]));
        end

        if (ld) begin
          exp_d = left_edge ? (old_full ? mb_l : '0) : cur_r;
          check("sr_d", 32'(SR_D), 32'(exp_d));
        end

        if (left_edge && !stop) begin
          cur_l   = old_full ? mb_l : '0;
          cur_r   = old_full ? mb_r : '0;
          mb_full = 1'b0;
        end

        if (stop) m_active = 1'b0;
        else      m_t++;
      end

      if (Sample_Valid && !old_full) begin
        mb_full = 1'b1;
        mb_l    = L_Data;
        mb_r    = R_Data;
      end
      run_prev = Run;
    end
  end

  // Stimulus tasks start and end 1 time unit after a rising edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic send_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    bit done = 1'b0;
    L_Data       = l;
    R_Data       = r;
    Sample_Valid = 1'b1;
    for (int i = 0; i < 4 * FRAME && !done; i++) begin
      @(negedge Clk);
      if (Sample_Ready) done = 1'b1;
    end
    @(posedge Clk);
    #1;
    Sample_Valid = 1'b0;
    check("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic wait_t(input int target);
    bit hit = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_active && ((m_t % FRAME) == target)) begin
        hit = 1'b1;
        break;
      end
      cycles(1);
    end
    check("slot_position_reached", 32'(hit), 32'd1);
  endtask

  initial begin
    Reset        = 1'b1;
    Run          = 1'b0;
    Sample_Valid = 1'b0;
    L_Data       = '0;
    R_Data       = '0;
    repeat (3) @(posedge Clk);
    #3 Reset = 1'b0;
    @(posedge Clk);
    #1;

    // Known pair buffered before Run: expect A5 then 3C on SDATA.
    send_pair(8'hA5, 8'h3C);
    Run = 1'b1;
    send_pair(DW'($urandom), DW'($urandom));
    cycles(2 * FRAME);

    // Random pairs with random gaps, some late enough to underrun.
    for (int k = 0; k < 6; k++) begin
      cycles($urandom_range(0, FRAME + FRAME / 2));
      send_pair(DW'($urandom), DW'($urandom));
    end

    // No source data: zeros and one underrun per frame.
    cycles(3 * FRAME);

    // Transfer in the very cycle of a left load with an empty buffer.
    wait_t(DIV - 1);
    L_Data       = DW'($urandom);
    R_Data       = DW'($urandom);
    Sample_Valid = 1'b1;
    cycles(1);
    Sample_Valid = 1'b0;
    check("ready_after_xfer", 32'(Sample_Ready), 32'd0);
    cycles(2 * FRAME);

    // Run dropped mid-left-slot: right slot completes, then idle.
    send_pair(DW'($urandom), DW'($urandom));
    wait_t(10);
    Run = 1'b0;
    cycles(2 * FRAME);
    check("drain_enable", 32'(SR_Enable), 32'd0);
    check("drain_bclk",   32'(BCLK),      32'd0);
    check("drain_lrclk",  32'(LRCLK),     32'd0);
    cycles(10);

    // Run re-asserted during DRAIN: streaming continues without a gap.
    Run = 1'b1;
    send_pair(DW'($urandom), DW'($urandom));
    wait_t(10);
    Run = 1'b0;
    wait_t(40);
    Run = 1'b1;
    send_pair(DW'($urandom), DW'($urandom));
    cycles(2 * FRAME);

    // Asynchronous reset mid-slot with a full pair buffer.
    wait_t(10);
    send_pair(DW'($urandom), DW'($urandom));
    wait_t(20);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_bclk",   32'(BCLK),         32'd0);
    check("async_rst_lrclk",  32'(LRCLK),        32'd0);
    check("async_rst_enable", 32'(SR_Enable),    32'd0);
    check("async_rst_ready",  32'(Sample_Ready), 32'd1);
    check("async_rst_load",   32'(SR_Load),      32'd0);
    cycles(3);
    #2 Reset = 1'b0;
    @(posedge Clk);
    #1;
    send_pair(DW'($urandom), DW'($urandom));
    cycles(FRAME + 10);
    Run = 1'b0;
    cycles(2 * FRAME);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2s_tx_sequencer.md
Name: i2s_tx_sequencer

Overview:
Sequences one external parallel-load/serial-out shift register to stream stereo samples as an I2S transmitter (Philips format, MSB first, 1-bit LRCLK lead).
- Generates BCLK and LRCLK from the system clock.
- Drives the shift register's Load, Shift_En, Enable and D inputs, and returns its serial MSB as SDATA.
- Sits between the FM synthesis output (sample source) and the audio codec pins; owns the only path to the shift register.

Parameters:
D_WIDTH, 32, bits per channel slot; must be at least 2 and equal to the shift register width.
BCLK_DIV, 8, Clk cycles per BCLK period; even, at least 2.

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Run  in  1  level; 1 = stream, 0 = stop after the current frame
L_Data  in  D_WIDTH  left sample
R_Data  in  D_WIDTH  right sample
Sample_Valid  in  1  source has an L/R pair
Sample_Ready  out  1  pair buffer empty; transfer on Valid&&Ready
SR_Load  out  1  to shift register Load
SR_Shift_En  out  1  to shift register Shift_En
SR_Enable  out  1  to shift register Enable
SR_D  out  D_WIDTH  to shift register D
SR_Shift_In  out  1  constant 0
SR_Shift_Out  in  1  from shift register Shift_Out (MSB)
BCLK  out  1  I2S bit clock
LRCLK  out  1  I2S word select; 0 = left
SDATA  out  1  I2S serial data = SR_Shift_Out
Underrun  out  1  one-Clk pulse: left slot started with an empty buffer

Behaviour:
- Reset values:
  - All registered outputs are 0; Sample_Ready is 1.
  - State is IDLE; div_cnt = 0; bit_cnt = D_WIDTH-1; chan = RIGHT; pair buffer is empty.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 and wraps; it advances only outside IDLE.
  - BCLK is registered: 0 while div_cnt < BCLK_DIV/2, 1 otherwise.
  - fe (falling-edge strobe) = div_cnt == BCLK_DIV-1 and not IDLE. It is combinational, and its cycle is the cycle before BCLK falls.
- Slot sequencing on fe:
  - If bit_cnt == D_WIDTH-1: SR_Load=1 for that cycle, bit_cnt<=0, chan flips, SR_D = word for the new channel.
  - Otherwise: SR_Shift_En=1 for that cycle, bit_cnt++.
  - SR_Load and SR_Shift_En are never both 1, and each is high only in fe cycles, so the shift register updates on the same Clk edge at which BCLK falls.
- LRCLK:
  - Registered; it updates on fe with bit_cnt == D_WIDTH-2, taking the value of the upcoming channel (1-bit lead).
  - On the first slot after IDLE it is already 0.
- Data path:
  - Loading a LEFT slot moves the pair buffer into the active L/R registers and empties the buffer.
  - If the buffer is empty at that point, the active registers load 0 and Underrun pulses in the same cycle.
  - A RIGHT slot loads the active R register.
- Handshake:
  - Sample_Ready = buffer empty.
  - A transfer in the same cycle as a left-slot load: the load takes the old buffer content (or zero plus Underrun if empty); the new pair is written to the buffer and Sample_Ready falls next cycle.
- FSM (IDLE/RUN/DRAIN):
  - IDLE: SR_Enable=0, BCLK=0, LRCLK=0. Run=1 moves to RUN with div_cnt=0, bit_cnt=D_WIDTH-1, chan=RIGHT, so the first fe loads LEFT.
  - RUN: Run=0 moves to DRAIN.
  - DRAIN: continues streaming. Run=1 returns to RUN. fe with bit_cnt==D_WIDTH-1 and chan==RIGHT moves to IDLE; no load is issued and BCLK and LRCLK return to 0.
  - SR_Enable = 1 in RUN/DRAIN, so a disabled shift register streams 0 in IDLE.
- Async Reset mid-frame aborts immediately to reset values. The buffered pair is discarded.

Decomposition:
- Package i2s_pkg holds:
  - the state enum typedef (IDLE, RUN, DRAIN);
  - chan constants LEFT=0 and RIGHT=1;
  - the LRCLK polarity constant.
- Sub-module i2s_bclk_gen contains div_cnt, the registered BCLK, and the fe strobe, with run and BCLK_DIV as parameters.

Test Plan:
- D_WIDTH=8, BCLK_DIV=4. Reset, then Run=1 with pair L=8'hA5, R=8'h3C already valid:
  - SR_Load appears 3 Clk after Run.
  - Then SDATA over 16 BCLK falls is 1010_0101 0011_1100.
  - LRCLK rises one BCLK before the first R bit.
- BCLK period: 4 Clk with 50% duty. Exactly one SR_Load or SR_Shift_En per BCLK fall, never both.
- Run=1 with no Sample_Valid:
  - Underrun pulses once per frame at each left load.
  - SDATA is all 0.
  - Sample_Ready stays 1.
- Sample_Valid asserted in the same cycle as a left load, with buffer empty:
  - Underrun=1 and zeros are sent.
  - The new pair is sent in the next frame.
  - Sample_Ready is 0 for the cycle after the transfer.
- Run dropped mid-left-slot:
  - The right slot completes.
  - Then IDLE: BCLK=0, LRCLK=0, SR_Enable=0, no further loads.
  - Run re-asserted during DRAIN continues without a gap.
- Reset asserted asynchronously mid-slot (between Clk edges):
  - Outputs go to reset values immediately.
  - Sample_Ready=1.
  - After release plus Run=1, streaming restarts at a LEFT slot.
